// File: rtl/prbs31_pkg.sv
// Shared definitions for the PRBS31 (x^31 + x^28 + 1) generator and checker.
package prbs31_pkg;

    // LFSR length and the two feedback taps of x^31 + x^28 + 1
    localparam int PRBS_LEN = 31;
    localparam int TAP_HI   = 30;
    localparam int TAP_LO   = 27;

    // Checker synchronisation states
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/prbs31_step.sv
// One PRBS31 step: predicted next bit and the self-advanced LFSR contents.
// Shared by the generator and the checker so both ends use the same polynomial.
module prbs31_step
    import prbs31_pkg::*;
(
    input  logic [PRBS_LEN-1:0] sr,
    output logic                pred,
    output logic [PRBS_LEN-1:0] sr_adv
);

    assign pred   = sr[TAP_HI] ^ sr[TAP_LO];
    assign sr_adv = {sr[PRBS_LEN-2:0], pred};

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 receive checker: self-seeds from the stream, verifies, then counts
// bit errors while locked, dropping lock when too many errors land in a window.
module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int ERR_CNT_W   = 16,
    parameter int BIT_CNT_W   = 24,
    parameter int LOCK_THRESH = 32,
    parameter int WIN_LEN     = 64,
    parameter int UNLOCK_ERRS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 data_in,
    input  logic                 data_valid,
    input  logic                 invert,
    input  logic                 clear_cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [BIT_CNT_W-1:0] bit_count
);

    localparam int FILL_W  = $clog2(PRBS_LEN);
    localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
    localparam int WIN_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int WERR_W  = $clog2(UNLOCK_ERRS + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST   = FILL_W'(PRBS_LEN - 1);
    localparam logic [MATCH_W-1:0] MATCH_LOCK  = MATCH_W'(LOCK_THRESH);
    localparam logic [WIN_W-1:0]   WIN_LAST    = WIN_W'(WIN_LEN - 1);
    localparam logic [WERR_W-1:0]  WERR_UNLOCK = WERR_W'(UNLOCK_ERRS);

    state_t                state_reg, state_next;
    logic [PRBS_LEN-1:0]   sr_reg, sr_next;
    logic [FILL_W-1:0]     fill_reg, fill_next;
    logic [MATCH_W-1:0]    match_reg, match_next;
    logic [WIN_W-1:0]      win_cnt_reg, win_cnt_next;
    logic [WERR_W-1:0]     win_err_reg, win_err_next;
    logic                  locked_reg, locked_next;
    logic                  err_pulse_reg, err_pulse_next;
    logic [ERR_CNT_W-1:0]  err_cnt_reg, err_cnt_next;
    logic [BIT_CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;

    logic                  pred;
    logic [PRBS_LEN-1:0]   sr_adv;
    logic                  sample;
    logic                  rx;
    logic [PRBS_LEN-1:0]   sr_shift;
    logic [MATCH_W-1:0]    match_inc;
    logic [WERR_W-1:0]     win_err_inc;
    logic                  bit_err;

    prbs31_step u_step (
        .sr     (sr_reg),
        .pred   (pred),
        .sr_adv (sr_adv)
    );

    assign sample      = ena & data_valid;
    assign rx          = data_in ^ invert;
    assign sr_shift    = {sr_reg[PRBS_LEN-2:0], rx};
    assign match_inc   = match_reg + MATCH_W'(1);
    assign bit_err     = (rx != pred);
    assign win_err_inc = win_err_reg + WERR_W'(1);

    // Next-state logic: FSM transitions, LFSR update and all counters
    always_comb begin
        state_next     = state_reg;
        sr_next        = sr_reg;
        fill_next      = fill_reg;
        match_next     = match_reg;
        win_cnt_next   = win_cnt_reg;
        win_err_next   = win_err_reg;
        err_pulse_next = 1'b0;
        err_cnt_next   = err_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;

        if (sample) begin
            case (state_reg)
                HUNT: begin
                    // Fill the LFSR straight from the line; an all-zero seed
                    // would lock onto a dead stream, so refill instead.
                    sr_next = sr_shift;
                    if (fill_reg == FILL_LAST) begin
                        fill_next = '0;
                        if (sr_shift != '0) begin
                            state_next = VERIFY;
                            match_next = '0;
                        end
                    end else begin
                        fill_next = fill_reg + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    sr_next = sr_shift;
                    if (bit_err) begin
                        state_next = HUNT;
                        fill_next  = '0;
                    end else begin
                        match_next = match_inc;
                        if (match_inc == MATCH_LOCK) begin
                            state_next   = LOCKED;
                            win_cnt_next = '0;
                            win_err_next = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so a bad bit never poisons the seed
                    sr_next = sr_adv;
                    if (bit_cnt_reg != '1)
                        bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(1);
                    if (bit_err) begin
                        err_pulse_next = 1'b1;
                        if (err_cnt_reg != '1)
                            err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
                    end
                    if (bit_err && (win_err_inc == WERR_UNLOCK)) begin
                        state_next   = HUNT;
                        fill_next    = '0;
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else if (win_cnt_reg == WIN_LAST) begin
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else begin
                        win_cnt_next = win_cnt_reg + WIN_W'(1);
                        win_err_next = bit_err ? win_err_inc : win_err_reg;
                    end
                end
                default: begin
                    state_next = HUNT;
                    fill_next  = '0;
                end
            endcase
        end

        // Clear beats any increment on the same cycle; the pulse is unaffected
        if (ena && clear_cnt) begin
            err_cnt_next = '0;
            bit_cnt_next = '0;
        end

        locked_next = (state_next == LOCKED);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= HUNT;
            sr_reg        <= '0;
            fill_reg      <= '0;
            match_reg     <= '0;
            win_cnt_reg   <= '0;
            win_err_reg   <= '0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
            err_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            sr_reg        <= sr_next;
            fill_reg      <= fill_next;
            match_reg     <= match_next;
            win_cnt_reg   <= win_cnt_next;
            win_err_reg   <= win_err_next;
            locked_reg    <= locked_next;
            err_pulse_reg <= err_pulse_next;
            err_cnt_reg   <= err_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
        end
    end

    assign locked    = locked_reg;
    assign err_pulse = err_pulse_reg;
    assign err_count = err_cnt_reg;
    assign bit_count = bit_cnt_reg;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: lock, single error, burst unlock,
// clear/reset behaviour, polarity and all-zero input.
module tb_prbs31_checker;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        data_in;
    logic        data_valid;
    logic        invert;
    logic        clear_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [23:0] bit_count;

    int          errors;
    int          checks;
    logic [30:0] gen_sr;
    logic        inv_stream;
    logic        saw_lock;

    prbs31_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .data_in    (data_in),
        .data_valid (data_valid),
        .invert     (invert),
        .clear_cnt  (clear_cnt),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .bit_count  (bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one valid bit on the line and wait for it to be sampled
    task automatic send_raw(input logic b);
        data_in    = b;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        saw_lock   = saw_lock | locked;
    endtask

    // Next generator bit (seed 0x7FFFFFFF), optionally corrupted
    task automatic send(input logic flip);
        logic b;
        b      = gen_sr[30] ^ gen_sr[27];
        gen_sr = {gen_sr[29:0], b};
        send_raw(b ^ flip ^ inv_stream);
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) send(1'b0);
    endtask

    task automatic idle(input int n);
        data_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        gen_sr     = 31'h7FFF_FFFF;
        inv_stream = 1'b0;
        saw_lock   = 1'b0;
        rst_n      = 1'b0;
        ena        = 1'b1;
        data_in    = 1'b0;
        data_valid = 1'b0;
        invert     = 1'b0;
        clear_cnt  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_locked", locked, 0);
        check("reset_err_pulse", err_pulse, 0);
        check("reset_err_count", err_count, 0);
        check("reset_bit_count", bit_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean lock: 63 bits to lock, then 1000 clean bits
        send_n(62);
        check("clean_not_locked_62", locked, 0);
        send(1'b0);
        check("clean_locked_63", locked, 1);
        send_n(1000);
        check("clean_err_count", err_count, 0);
        check("clean_bit_count", bit_count, 1000);

        // Single error while locked
        send(1'b1);
        check("single_err_pulse", err_pulse, 1);
        check("single_err_count", err_count, 1);
        check("single_locked", locked, 1);
        check("single_bit_count", bit_count, 1001);
        send(1'b0);
        check("single_next_pulse", err_pulse, 0);
        check("single_next_count", err_count, 1);

        // Move to the start of a fresh window (locked bit index 1024), clear counts in a gap
        send_n(22);
        clear_cnt = 1'b1;
        idle(1);
        clear_cnt = 1'b0;
        check("clear_err_count", err_count, 0);
        check("clear_bit_count", bit_count, 0);
        check("clear_gap_locked", locked, 1);

        // Burst of 8 errors in one window drops lock
        for (int i = 0; i < 7; i++) send(1'b1);
        check("burst7_locked", locked, 1);
        check("burst7_err_count", err_count, 7);
        send(1'b1);
        check("burst8_unlocked", locked, 0);
        check("burst8_err_pulse", err_pulse, 1);
        check("burst8_err_count", err_count, 8);
        send_n(62);
        check("relock_not_yet", locked, 0);
        check("relock_err_kept", err_count, 8);
        send(1'b0);
        check("relock_locked", locked, 1);
        check("relock_bit_count", bit_count, 8);

        // Clear coincident with an error
        clear_cnt = 1'b1;
        send(1'b1);
        clear_cnt = 1'b0;
        check("clr_err_err_count", err_count, 0);
        check("clr_err_pulse", err_pulse, 1);
        check("clr_err_bit_count", bit_count, 0);
        check("clr_err_locked", locked, 1);

        // Asynchronous reset mid-lock, right after an error pulse
        send_n(10);
        send(1'b1);
        check("pre_rst_pulse", err_pulse, 1);
        check("pre_rst_err_count", err_count, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_locked", locked, 0);
        check("async_rst_pulse", err_pulse, 0);
        check("async_rst_err_count", err_count, 0);
        check("async_rst_bit_count", bit_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Re-lock with valid gaps: lock still needs exactly 63 valid bits
        for (int i = 0; i < 62; i++) begin
            send(1'b0);
            if (i % 3 == 0) idle(2);
        end
        check("gap_not_locked_62", locked, 0);
        send(1'b0);
        check("gap_locked_63", locked, 1);

        // Polarity: inverted stream without invert never locks
        do_reset();
        inv_stream = 1'b1;
        invert     = 1'b0;
        saw_lock   = 1'b0;
        send_n(300);
        check("inv_no_lock", saw_lock, 0);
        check("inv_no_errs", err_count, 0);

        // Inverted stream with invert set locks cleanly
        do_reset();
        invert = 1'b1;
        send_n(62);
        check("inv_fix_not_locked", locked, 0);
        send(1'b0);
        check("inv_fix_locked", locked, 1);
        send_n(100);
        check("inv_fix_err_count", err_count, 0);
        check("inv_fix_bit_count", bit_count, 100);

        // All-zero input stays in HUNT
        do_reset();
        invert     = 1'b0;
        inv_stream = 1'b0;
        saw_lock   = 1'b0;
        for (int i = 0; i < 500; i++) send_raw(1'b0);
        check("zero_no_lock", saw_lock, 0);
        check("zero_bit_count", bit_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
